// File: rtl/cmd_cfg_unit.sv
// Command decoder/config block: executes one opcode+operand from the UART receiver, updates
// setpoints and sequences battery conversion and motor spin-up/inertial calibration.
module cmd_cfg_unit #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        clr_cmd_rdy,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        cmd_ack,
  output logic [7:0]  resp,
  output logic        send_resp,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst,
  input  logic [7:0]  batt,
  output logic        strt_cnv,
  input  logic        cnv_cmplt,
  output logic        strt_cal,
  output logic        inertial_cal,
  input  logic        cal_done,
  output logic        motors_off
);

  localparam int unsigned TimerW = FAST_SIM ? 9 : 26;
  localparam logic [7:0] RespAck  = 8'hA5;
  localparam logic [7:0] RespNack = 8'hFF;

  typedef enum logic [1:0] {StIdle, StBattWait, StSpinup, StCalWait} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [15:0]         d_ptch_q, d_ptch_d, d_roll_q, d_roll_d, d_yaw_q, d_yaw_d;
  logic [8:0]          thrst_q, thrst_d;
  logic [7:0]          resp_q, resp_d;
  logic                cmd_ack_q, cmd_ack_d, send_resp_q, send_resp_d;
  logic                strt_cnv_q, strt_cnv_d, strt_cal_q, strt_cal_d;
  logic                inertial_cal_q, inertial_cal_d, motors_off_q, motors_off_d;
  logic                done;
  logic [7:0]          done_resp;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    d_ptch_d       = d_ptch_q;
    d_roll_d       = d_roll_q;
    d_yaw_d        = d_yaw_q;
    thrst_d        = thrst_q;
    resp_d         = resp_q;
    motors_off_d   = motors_off_q;
    inertial_cal_d = inertial_cal_q;
    strt_cnv_d     = 1'b0;
    strt_cal_d     = 1'b0;
    cmd_ack_d      = 1'b0;
    send_resp_d    = 1'b0;
    done           = 1'b0;
    done_resp      = RespAck;

    case (state_q)
      StIdle: begin
        // The ack cycle itself never accepts, so a lingering cmd_rdy is not re-executed.
        if (cmd_rdy && !cmd_ack_q) begin
          case (cmd)
            8'h01: begin
              strt_cnv_d = 1'b1;
              state_d    = StBattWait;
            end
            8'h02: begin d_ptch_d = data;      done = 1'b1; end
            8'h03: begin d_roll_d = data;      done = 1'b1; end
            8'h04: begin d_yaw_d  = data;      done = 1'b1; end
            8'h05: begin thrst_d  = data[8:0]; done = 1'b1; end
            8'h06: begin
              motors_off_d = 1'b0;
              timer_d      = '0;
              state_d      = StSpinup;
            end
            8'h07: begin
              d_ptch_d = '0;
              d_roll_d = '0;
              d_yaw_d  = '0;
              thrst_d  = '0;
              done     = 1'b1;
            end
            8'h08: begin motors_off_d = 1'b1; done = 1'b1; end
            default: begin
              done      = 1'b1;
              done_resp = RespNack;
            end
          endcase
        end
      end
      StBattWait: begin
        // A stale cnv_cmplt seen alongside strt_cnv belongs to the previous conversion.
        if (!strt_cnv_q && cnv_cmplt) begin
          done      = 1'b1;
          done_resp = batt;
          state_d   = StIdle;
        end
      end
      StSpinup: begin
        if (timer_q == {TimerW{1'b1}}) begin
          strt_cal_d     = 1'b1;
          inertial_cal_d = 1'b1;
          state_d        = StCalWait;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StCalWait: begin
        if (!strt_cal_q && cal_done) begin
          inertial_cal_d = 1'b0;
          done           = 1'b1;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      resp_d      = done_resp;
      send_resp_d = 1'b1;
      cmd_ack_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr_cmd_rdy) begin
    if (clr_cmd_rdy) begin
      state_q        <= StIdle;
      timer_q        <= '0;
      d_ptch_q       <= '0;
      d_roll_q       <= '0;
      d_yaw_q        <= '0;
      thrst_q        <= '0;
      resp_q         <= 8'h00;
      cmd_ack_q      <= 1'b0;
      send_resp_q    <= 1'b0;
      strt_cnv_q     <= 1'b0;
      strt_cal_q     <= 1'b0;
      inertial_cal_q <= 1'b0;
      motors_off_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      d_ptch_q       <= d_ptch_d;
      d_roll_q       <= d_roll_d;
      d_yaw_q        <= d_yaw_d;
      thrst_q        <= thrst_d;
      resp_q         <= resp_d;
      cmd_ack_q      <= cmd_ack_d;
      send_resp_q    <= send_resp_d;
      strt_cnv_q     <= strt_cnv_d;
      strt_cal_q     <= strt_cal_d;
      inertial_cal_q <= inertial_cal_d;
      motors_off_q   <= motors_off_d;
    end
  end

  assign cmd_ack      = cmd_ack_q;
  assign resp         = resp_q;
  assign send_resp    = send_resp_q;
  assign d_ptch       = d_ptch_q;
  assign d_roll       = d_roll_q;
  assign d_yaw        = d_yaw_q;
  assign thrst        = thrst_q;
  assign strt_cnv     = strt_cnv_q;
  assign strt_cal     = strt_cal_q;
  assign inertial_cal = inertial_cal_q;
  assign motors_off   = motors_off_q;

endmodule

// File: tb/tb_cmd_cfg_unit.sv
// Directed bench for cmd_cfg_unit: expected responses are queued at issue time and checked
// against the acknowledged response byte.
module tb_cmd_cfg_unit;

  logic        clk = 1'b0;
  logic        clr_cmd_rdy, cmd_rdy;
  logic [7:0]  cmd, resp, batt;
  logic [15:0] data, d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;
  logic        cmd_ack, send_resp, strt_cnv, cnv_cmplt, strt_cal, inertial_cal, cal_done;
  logic        motors_off;

  cmd_cfg_unit #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .clr_cmd_rdy(clr_cmd_rdy), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .cmd_ack(cmd_ack), .resp(resp), .send_resp(send_resp), .d_ptch(d_ptch),
    .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst), .batt(batt), .strt_cnv(strt_cnv),
    .cnv_cmplt(cnv_cmplt), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
    .cal_done(cal_done), .motors_off(motors_off)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] resp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n_cyc, cnv_at, cal_at, ical_cnt, stray;
  logic mo_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] c, input logic [15:0] d, input logic [7:0] r,
                       input string tag);
    exp_t e;
    @(negedge clk);
    cmd     = c;
    data    = d;
    cmd_rdy = 1'b1;
    e.tag   = tag;
    e.resp  = r;
    sb.push_back(e);
  endtask

  // Drops cmd_rdy after the first sampling edge, then watches for the ack within budget.
  task automatic wait_ack(input int budget);
    exp_t e;
    bit   seen;
    seen     = 1'b0;
    n_cyc    = 0;
    cnv_at   = 0;
    cal_at   = 0;
    ical_cnt = 0;
    while (!seen && n_cyc < budget) begin
      @(negedge clk);
      n_cyc++;
      cmd_rdy = 1'b0;
      if (n_cyc == 1) mo_first = motors_off;
      if (strt_cnv) cnv_at = n_cyc;
      if (strt_cal) cal_at = n_cyc;
      if (inertial_cal) ical_cnt++;
      if (cmd_ack) seen = 1'b1;
    end
    e = sb.pop_front();
    chk({e.tag, "_ack"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({e.tag, "_resp"}, 32'(resp), 32'(e.resp));
      chk({e.tag, "_send_resp"}, 32'(send_resp), 32'd1);
    end
  endtask

  initial begin
    exp_t e;
    clr_cmd_rdy = 1'b1;
    cmd_rdy     = 1'b0;
    cmd         = 8'h00;
    data        = 16'h0000;
    batt        = 8'h00;
    cnv_cmplt   = 1'b0;
    cal_done    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp", 32'(resp), 32'h00);
    chk("rst_motors_off", 32'(motors_off), 32'd1);
    chk("rst_setpoints", {d_ptch, d_roll | d_yaw}, 32'h0);
    chk("rst_thrst", 32'(thrst), 32'h0);
    chk("rst_pulses", {28'h0, cmd_ack, send_resp, strt_cnv, strt_cal}, 32'h0);
    chk("rst_inertial_cal", 32'(inertial_cal), 32'd0);
    clr_cmd_rdy = 1'b0;

    // Battery request: cnv_cmplt already high must be ignored in the strt_cnv cycle.
    batt      = 8'hFC;
    cnv_cmplt = 1'b1;
    issue(8'h01, 16'h0000, 8'hFC, "batt");
    wait_ack(20);
    chk("batt_strt_cnv_cycle", 32'(cnv_at), 32'd1);
    chk("batt_latency", 32'(n_cyc), 32'd3);

    issue(8'h02, 16'hFF0F, 8'hA5, "ptch");
    wait_ack(5);
    chk("ptch_latency", 32'(n_cyc), 32'd1);
    chk("ptch_val", 32'(d_ptch), 32'hFF0F);

    issue(8'h05, 16'h017F, 8'hA5, "thrst");
    wait_ack(5);
    chk("thrst_val", 32'(thrst), 32'h17F);
    chk("thrst_ptch_kept", 32'(d_ptch), 32'hFF0F);

    issue(8'h03, 16'h8001, 8'hA5, "roll");
    wait_ack(5);
    chk("roll_val", 32'(d_roll), 32'h8001);
    issue(8'h04, 16'h7FFE, 8'hA5, "yaw");
    wait_ack(5);
    chk("yaw_val", 32'(d_yaw), 32'h7FFE);

    issue(8'h3C, 16'h1234, 8'hFF, "nack");
    wait_ack(5);
    chk("nack_regs", {d_ptch, d_roll}, 32'hFF0F_8001);
    chk("nack_yaw_thrst", {d_yaw, 7'h0, thrst}, 32'h7FFE_017F);
    chk("nack_motors_off", 32'(motors_off), 32'd1);

    // cmd_rdy still high during the ack cycle must not start a second command.
    @(negedge clk);
    cmd     = 8'h3C;
    cmd_rdy = 1'b1;
    e.tag   = "hold";
    e.resp  = 8'hFF;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("hold_ack", 32'(cmd_ack), 32'd1);
    chk("hold_resp", 32'(resp), 32'(e.resp));
    @(negedge clk);
    chk("hold_ignored", 32'(cmd_ack), 32'd0);
    cmd_rdy = 1'b0;

    // A command offered while waiting on conversion is not accepted.
    cnv_cmplt = 1'b0;
    batt      = 8'h5A;
    issue(8'h01, 16'h0000, 8'h5A, "batt_busy");
    @(negedge clk);
    cmd = 8'h07;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (cmd_ack) stray++;
    end
    chk("busy_no_ack", 32'(stray), 32'd0);
    chk("busy_ptch_kept", 32'(d_ptch), 32'hFF0F);
    cmd_rdy   = 1'b0;
    cnv_cmplt = 1'b1;
    wait_ack(10);
    chk("busy_latency", 32'(n_cyc), 32'd1);

    // Calibration: 512-cycle spin-up, cal_done ignored in the strt_cal cycle.
    cal_done = 1'b1;
    issue(8'h06, 16'h0000, 8'hA5, "cal");
    wait_ack(700);
    chk("cal_motors_on", 32'(mo_first), 32'd0);
    chk("cal_strt_cal_cycle", 32'(cal_at), 32'd513);
    chk("cal_inertial_cycles", 32'(ical_cnt), 32'd2);
    chk("cal_latency", 32'(n_cyc), 32'd515);
    chk("cal_inertial_low", 32'(inertial_cal), 32'd0);

    issue(8'h07, 16'hFFFF, 8'hA5, "emer");
    wait_ack(5);
    chk("emer_setpoints", {d_ptch, d_roll | d_yaw}, 32'h0);
    chk("emer_thrst", 32'(thrst), 32'h0);
    chk("emer_motors_on", 32'(motors_off), 32'd0);

    issue(8'h08, 16'h0000, 8'hA5, "moff");
    wait_ack(5);
    chk("moff_val", 32'(motors_off), 32'd1);

    // Reset during spin-up aborts with no ack and no calibration.
    issue(8'h02, 16'h1234, 8'hA5, "pre_rst");
    wait_ack(5);
    @(negedge clk);
    cmd     = 8'h06;
    cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    chk("spin_motors_on", 32'(motors_off), 32'd0);
    repeat (10) @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("abort_motors_off", 32'(motors_off), 32'd1);
    chk("abort_ptch", 32'(d_ptch), 32'h0);
    stray = 0;
    repeat (600) begin
      @(negedge clk);
      if (cmd_ack || send_resp || strt_cal || inertial_cal) stray++;
    end
    chk("abort_silent", 32'(stray), 32'd0);

    issue(8'h05, 16'h00AA, 8'hA5, "post_rst");
    wait_ack(5);
    chk("post_rst_latency", 32'(n_cyc), 32'd1);
    chk("post_rst_thrst", 32'(thrst), 32'h0AA);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
